oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA controller inserted between `cpu` and `memory` on the shared byte bus. A CPU write to 0xFF46 starts a 160-byte copy from `{src_hi, 8'h00}` to OAM at 0xFE00–0xFE9F. While the copy runs, the block owns the memory ports and restricts the CPU to HRAM (0xFF80–0xFFFE). When idle it is a transparent pass-through, except that it owns register 0xFF46.

## Interface
Parameters:
- `CYCLES_PER_BYTE`, 4: clock cycles per transferred byte; must be ≥ 2.

Ports:
- `i_clk`  in  1  system clock
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_cpu_rd_addr`  in  16  CPU read address
- `o_cpu_rd_data`  out  8  read data returned to CPU
- `i_cpu_wr_en`  in  1  CPU write strobe
- `i_cpu_wr_addr`  in  16  CPU write address
- `i_cpu_wr_data`  in  8  CPU write data
- `o_mem_rd_addr`  out  16  memory read address
- `i_mem_rd_data`  in  8  memory read data, valid one cycle after its address
- `o_mem_wr_en`  out  1  memory write strobe
- `o_mem_wr_addr`  out  16  memory write address
- `o_mem_wr_data`  out  8  memory write data
- `o_dma_active`  out  1  high while a transfer is in progress

## Operation
- **Register 0xFF46**: 8-bit `src_hi`, reset 0x00.
  - A CPU write to it is consumed here, never forwarded to memory.
  - A read returns `src_hi` with the same 1-cycle latency as memory.
- **Effective source**: `src_hi` 0xE0–0xFF maps to `src_hi - 0x20` (echo RAM). The effective source is latched at start.
- **FSM states**: IDLE, START, XFER.
  - IDLE → START on a write to 0xFF46.
  - START → XFER after 1 cycle. `idx` = 0, `phase` = 0.
  - XFER: `phase` counts 0..CYCLES_PER_BYTE-1.
    - phase 0: `o_mem_rd_addr = src + idx`.
    - phase 1: `o_mem_wr_en = 1`, `o_mem_wr_addr = 0xFE00 + idx`, `o_mem_wr_data = i_mem_rd_data`.
    - At the last phase, `idx` increments.
    - After the last phase of `idx` = 159: XFER → IDLE.
- **Restart**: a write to 0xFF46 in START or XFER returns to START with the new source and `idx` = 0. This holds even if it coincides with the final byte.
- **`o_dma_active`**: high in START and XFER.
- **CPU access during START and XFER**:
  - *Writes*: HRAM writes are forwarded only in phases ≠ 1, and during START. In phase 1 they are dropped. All other addresses except 0xFF46 are dropped.
  - *Reads*: HRAM reads are forwarded in phases ≠ 0, and during START.
  - A read is *blocked* if it is to a non-HRAM, non-0xFF46 address, or if it is an HRAM read in phase 0.
  - A 1-bit registered flag records "previous-cycle read blocked". When set, `o_cpu_rd_data = 0xFF`; otherwise it carries `i_mem_rd_data` (or `src_hi` for 0xFF46).
- **IDLE**: all CPU signals pass straight to memory (except 0xFF46), with no added latency.
- **Reset**, asynchronous, at any time including mid-transfer:
  - State IDLE, `src_hi` = 0, `idx` = 0, `phase` = 0, blocked flag = 0.
  - `o_dma_active` = 0, `o_mem_wr_en` = 0.
  - A partial copy is abandoned and not resumed.
  - With no CPU activity, `o_mem_rd_addr` and `o_mem_wr_addr` follow the CPU inputs; `o_cpu_rd_data` = `i_mem_rd_data`.

## Timing
- Write to 0xFF46 sampled at edge t:
  - START during cycle t+1.
  - Byte i read address presented during t+2+i·CPB.
  - Byte i write during t+3+i·CPB.
- `o_dma_active` is high from t+1 through t+1+160·CPB, then low: 1+160·CPB cycles in total (641 for CPB = 4).
- `idx` is 8 bits and never exceeds 159. `src + idx` never carries into the high byte.
- `phase` width is `$clog2(CYCLES_PER_BYTE)`.
- All memory-side outputs are combinational from state and CPU inputs. State, `idx`, `phase`, `src_hi` and the blocked flag are registered.

## Structure
- **Shared package `gb_pkg`**:
  - `DMA_REG_ADDR` = 16'hFF46, `OAM_BASE` = 16'hFE00, `DMA_LEN` = 160.
  - `HRAM_LO` = 16'hFF80, `HRAM_HI` = 16'hFFFE.
  - `dma_state_t` enum {IDLE, START, XFER}.
- No sub-module; the FSM and bus mux live in one file.
- `top` instantiates `oam_dma` between `u_cpu` and `u_memory`.

## Test plan
- **Basic copy**: preload 0xC000–0xC09F with i^0x5A; write 0xC0 to 0xFF46.
  - 0xFE00–0xFE9F equal i^0x5A.
  - `o_dma_active` is high for exactly 641 cycles.
  - First write at t+3, last at t+639.
- **Echo mapping**: write 0xE1 to 0xFF46 → reads come from 0xC100–0xC19F.
- **CPU lockout**: during DMA, a read of 0xC000 returns 0xFF and a write to 0xC000 leaves memory unchanged. A write then read of 0xFF90 in phases 2/3 returns the written value; a read of 0xFF46 returns 0xC0.
- **Restart**: write 0xC1 to 0xFF46 at idx = 80.
  - Restart from idx 0; final OAM holds the 0xC1 page.
  - Active lasts 641 cycles from the second write.
- **Reset mid-copy**: assert `i_rst` at idx = 50.
  - `o_dma_active` = 0 immediately (asynchronously); `src_hi` reads back 0x00.
  - OAM bytes 50+ are untouched.
  - CPU pass-through works on the next cycle.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared constants and types for the Game Boy style bus blocks.
package gb_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          DMA_LEN      = 160;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    // True for addresses the CPU may still reach while a DMA owns the bus.
    function automatic logic is_hram(input logic [15:0] addr);
        return (addr >= HRAM_LO) && (addr <= HRAM_HI);
    endfunction

    // Pages 0xE0-0xFF are echo RAM and fold back onto 0xC0-0xDF.
    function automatic logic [7:0] eff_src_page(input logic [7:0] src_hi);
        return (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA controller sitting between the CPU and memory on the byte bus.
// Bus protocol: no handshake. Reads are address-in, data-out one cycle later;
// writes complete in the cycle the strobe is high. While a copy runs the
// controller owns the memory ports and the CPU is confined to HRAM.
module oam_dma
    import gb_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_rd_addr,
    output logic [7:0]  o_cpu_rd_data,
    input  logic        i_cpu_wr_en,
    input  logic [15:0] i_cpu_wr_addr,
    input  logic [7:0]  i_cpu_wr_data,
    output logic [15:0] o_mem_rd_addr,
    input  logic [7:0]  i_mem_rd_data,
    output logic        o_mem_wr_en,
    output logic [15:0] o_mem_wr_addr,
    output logic [7:0]  o_mem_wr_data,
    output logic        o_dma_active
);

    localparam int            PW         = $clog2(CYCLES_PER_BYTE);
    localparam logic [PW-1:0] LAST_PHASE = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [PW-1:0] RD_PHASE   = PW'(0);
    localparam logic [PW-1:0] WR_PHASE   = PW'(1);
    localparam logic [7:0]    LAST_IDX   = 8'(DMA_LEN - 1);

    dma_state_t    state_q, state_d;
    logic [7:0]    src_hi_q, src_hi_d;   // raw register value, read back by CPU
    logic [7:0]    src_q, src_d;         // effective source page latched at start
    logic [7:0]    idx_q, idx_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          blk_q, blk_d;         // previous-cycle CPU read was blocked
    logic          reg_rd_q, reg_rd_d;   // previous-cycle CPU read targeted 0xFF46

    logic dma_reg_wr;
    logic active;
    logic xfer_rd;
    logic xfer_wr;

    assign dma_reg_wr   = i_cpu_wr_en && (i_cpu_wr_addr == DMA_REG_ADDR);
    assign active       = (state_q != IDLE);
    assign xfer_rd      = (state_q == XFER) && (phase_q == RD_PHASE);
    assign xfer_wr      = (state_q == XFER) && (phase_q == WR_PHASE);
    assign o_dma_active = active;

    // State, counters and register file; reset abandons any copy in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            src_hi_q <= 8'h00;
            src_q    <= 8'h00;
            idx_q    <= 8'h00;
            phase_q  <= '0;
            blk_q    <= 1'b0;
            reg_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            src_q    <= src_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            blk_q    <= blk_d;
            reg_rd_q <= reg_rd_d;
        end
    end

    // Next-state: walk phases per byte and bytes per copy; a register write always (re)starts.
    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        src_d    = src_q;
        idx_d    = idx_q;
        phase_d  = phase_q;

        case (state_q)
            IDLE: ;
            START: begin
                state_d = XFER;
                idx_d   = 8'h00;
                phase_d = '0;
            end
            XFER: begin
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 8'h00;
                    end else begin
                        idx_d = idx_q + 8'h01;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Restart wins even over the final byte of a running copy.
        if (dma_reg_wr) begin
            state_d  = START;
            src_hi_d = i_cpu_wr_data;
            src_d    = eff_src_page(i_cpu_wr_data);
            idx_d    = 8'h00;
            phase_d  = '0;
        end

        reg_rd_d = (i_cpu_rd_addr == DMA_REG_ADDR);
        blk_d    = active && !reg_rd_d &&
                   (!is_hram(i_cpu_rd_addr) || xfer_rd);
    end

    // Bus mux: pass-through when idle, DMA owns the read port in phase 0 and the write port in phase 1.
    always_comb begin
        o_mem_rd_addr = i_cpu_rd_addr;
        o_mem_wr_en   = i_cpu_wr_en && !dma_reg_wr;
        o_mem_wr_addr = i_cpu_wr_addr;
        o_mem_wr_data = i_cpu_wr_data;

        if (active) begin
            o_mem_wr_en = i_cpu_wr_en && is_hram(i_cpu_wr_addr);
        end
        if (xfer_rd) begin
            o_mem_rd_addr = {src_q, idx_q};
        end
        if (xfer_wr) begin
            o_mem_wr_en   = 1'b1;
            o_mem_wr_addr = OAM_BASE + {8'h00, idx_q};
            o_mem_wr_data = i_mem_rd_data;
        end
    end

    // Read-data return: blocked reads see open bus, 0xFF46 reads see the register.
    always_comb begin
        if (blk_q) begin
            o_cpu_rd_data = 8'hFF;
        end else if (reg_rd_q) begin
            o_cpu_rd_data = src_hi_q;
        end else begin
            o_cpu_rd_data = i_mem_rd_data;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: 64 KiB memory model on the bus, a scoreboard of expected
// OAM writes checked by a monitor, and a behavioural model of OAM contents.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_rd_addr;
    logic [7:0]  cpu_rd_data;
    logic        cpu_wr_en;
    logic [15:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic [15:0] mem_rd_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [7:0]  mem_wr_data;
    logic        dma_active;

    oam_dma #(.CYCLES_PER_BYTE(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cpu_rd_addr (cpu_rd_addr),
        .o_cpu_rd_data (cpu_rd_data),
        .i_cpu_wr_en   (cpu_wr_en),
        .i_cpu_wr_addr (cpu_wr_addr),
        .i_cpu_wr_data (cpu_wr_data),
        .o_mem_rd_addr (mem_rd_addr),
        .i_mem_rd_data (mem_rd_data),
        .o_mem_wr_en   (mem_wr_en),
        .o_mem_wr_addr (mem_wr_addr),
        .o_mem_wr_data (mem_wr_data),
        .o_dma_active  (dma_active)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    int         cyc = 0;

    // Synchronous memory: read data one cycle after address, write in-cycle.
    always @(posedge clk) begin
        logic [7:0] rd_tmp;
        rd_tmp = mem[mem_rd_addr];
        if (mem_wr_en) mem[mem_wr_addr] = mem_wr_data;
        mem_rd_data <= rd_tmp;
        cyc <= cyc + 1;
    end

    // ---------------- scoreboard / reference model ----------------
    int          total = 0;
    int          bad = 0;
    logic [23:0] exp_q[$];          // {oam addr, data} in expected order
    logic [7:0]  oam_ref [0:159];   // expected OAM contents
    logic [7:0]  new_oam [0:159];   // contents of the copy in flight
    int          act_cnt = 0;
    int          first_wr = -1;
    int          last_wr = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of a copy: 160 bytes from the effective page, in index order.
    task automatic push_copy(input logic [7:0] src_hi);
        logic [7:0] page;
        page = (src_hi >= 8'hE0) ? src_hi - 8'h20 : src_hi;
        exp_q.delete();
        for (int i = 0; i < 160; i++) begin
            new_oam[i] = mem[{page, 8'(i)}];
            exp_q.push_back({16'hFE00 + 16'(i), new_oam[i]});
        end
    endtask

    // Monitor: count active cycles and score every write landing in OAM.
    always @(negedge clk) begin
        if (dma_active) act_cnt++;
        if (mem_wr_en && mem_wr_addr >= 16'hFE00 && mem_wr_addr <= 16'hFE9F) begin
            if (exp_q.size() == 0) begin
                chk("unexpected oam write", {8'h00, mem_wr_addr, mem_wr_data}, 32'hFFFF_FFFF);
            end else begin
                chk("oam write", {8'h00, mem_wr_addr, mem_wr_data}, {8'h00, exp_q.pop_front()});
            end
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        tick();
        cpu_wr_en = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
        cpu_rd_addr = a;
        tick();
        d = cpu_rd_data;
    endtask

    // Start (or restart) a copy; t is the cycle label right after the sampling edge.
    task automatic start_dma(input logic [7:0] s, output int t);
        cpu_wr(16'hFF46, s);
        t        = cyc;
        act_cnt  = 0;
        first_wr = -1;
        last_wr  = -1;
        push_copy(s);
    endtask

    task automatic wait_phase(input int t, input int p);
        while (((cyc - t - 1) % 4) != p) tick();
    endtask

    task automatic finish_copy(input string name, input int t);
        int n;
        int nerr;
        n = 0;
        while (dma_active && n < 3000) begin
            tick();
            n++;
        end
        chk({name, " finished"}, {31'd0, dma_active}, 32'd0);
        for (int i = 0; i < 160; i++) oam_ref[i] = new_oam[i];
        chk({name, " active cycles"}, act_cnt, 641);
        chk({name, " first write"}, first_wr, t + 2);
        chk({name, " last write"}, last_wr, t + 638);
        chk({name, " queue drained"}, exp_q.size(), 0);
        nerr = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== oam_ref[i]) nerr++;
        chk({name, " oam contents"}, nerr, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t, t2, nerr;
        logic [7:0] d, v, old;
        rst         = 1'b1;
        cpu_rd_addr = 16'hC000;
        cpu_wr_en   = 1'b0;
        cpu_wr_addr = 16'hD000;
        cpu_wr_data = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 160; i++) oam_ref[i] = mem[16'hFE00 + 16'(i)];

        // Reset state and pass-through while held in reset.
        repeat (3) @(posedge clk);
        #1;
        chk("reset active", {31'd0, dma_active}, 32'd0);
        chk("reset wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("reset rd addr follows", {16'd0, mem_rd_addr}, 32'hC000);
        chk("reset wr addr follows", {16'd0, mem_wr_addr}, 32'hD000);
        rst = 1'b0;
        tick();
        cpu_rd(16'hFF46, d);
        chk("src_hi after reset", d, 8'h00);

        // Idle pass-through.
        v = 8'($urandom);
        cpu_wr(16'hD123, v);
        chk("idle write", mem[16'hD123], v);
        cpu_rd(16'hD123, d);
        chk("idle read", d, v);

        // Basic copy with CPU lockout checks while it runs.
        old = mem[16'hFF46];
        start_dma(8'hC0, t);
        chk("ff46 not forwarded", mem[16'hFF46], old);
        repeat (40) tick();
        cpu_rd(16'hC000, d);
        chk("lockout read", d, 8'hFF);
        old = mem[16'hC000];
        cpu_wr(16'hC000, ~old);
        chk("lockout write", mem[16'hC000], old);
        v = 8'($urandom);
        wait_phase(t, 2);
        cpu_wr(16'hFF90, v);
        cpu_rd(16'hFF90, d);
        chk("hram write/read", d, v);
        wait_phase(t, 1);
        old = mem[16'hFF91];
        cpu_wr(16'hFF91, ~old);
        chk("hram write phase1 dropped", mem[16'hFF91], old);
        wait_phase(t, 0);
        cpu_rd(16'hFF90, d);
        chk("hram read phase0 blocked", d, 8'hFF);
        cpu_rd(16'hFF46, d);
        chk("ff46 read during dma", d, 8'hC0);
        cpu_rd_addr = 16'hFF80;
        finish_copy("basic", t);

        // Echo-RAM source.
        start_dma(8'hE1, t);
        finish_copy("echo", t);
        cpu_rd(16'hFF46, d);
        chk("ff46 raw value", d, 8'hE1);

        // Restart mid-copy at idx 80.
        start_dma(8'hC0, t);
        repeat (1 + 80 * 4) tick();
        start_dma(8'hC1, t2);
        finish_copy("restart", t2);

        // Randomised sources, including echo pages.
        for (int k = 0; k < 2; k++) begin
            start_dma(8'($urandom_range(8'hC2, 8'hFD)), t);
            finish_copy("random", t);
        end

        // Reset at idx 50 phase 0: bytes 0..49 done, the rest untouched.
        start_dma(8'hD0, t);
        repeat (201) tick();
        rst = 1'b1;
        #1;
        chk("async reset active", {31'd0, dma_active}, 32'd0);
        chk("async reset wr_en", {31'd0, mem_wr_en}, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 50; i++) oam_ref[i] = new_oam[i];
        tick();
        tick();
        rst = 1'b0;
        v = 8'($urandom);
        cpu_wr(16'hD200, v);
        chk("post-reset write", mem[16'hD200], v);
        cpu_rd(16'hD200, d);
        chk("post-reset read", d, v);
        cpu_rd(16'hFF46, d);
        chk("src_hi after mid reset", d, 8'h00);
        repeat (20) tick();
        nerr = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== oam_ref[i]) nerr++;
        chk("oam after reset", nerr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
